vid_pattern_src: RTL and testbench
==================================

Name: vid_pattern_src

Overview:
- Video source for the gray/zone statistics path: generates the pixel-timing stream (vs, hs, de, 8-bit R/G/B) that the zone-brightness receiver consumes.
- Same 1280x800 timing as the receiver, so zone statistics can be checked against known images in simulation and on the board without an HDMI input.
- Provides solid, colour-bar, gray-ramp, zone-checker and moving-box patterns, selected per frame.

Parameters:
- H_SYNC, 100, hsync width in pixel clocks
- H_BACK, 80, horizontal back porch
- H_VALID, 1280, active pixels per line
- H_TOTAL, 1520, total clocks per line (front porch = 60)
- V_SYNC, 99, vsync width in lines
- V_BACK, 19, vertical back porch
- V_VALID, 800, active lines
- V_TOTAL, 938, total lines per frame
- ZONE, 53, zone cell size in pixels (matches receiver partitioning)
- BOX, 64, moving-box side length

Ports:
- I_pix_clk  in  1  pixel clock
- I_rst_n  in  1  reset; synchronous, active-low
- I_pat_sel  in  3  pattern select; sampled at frame start only
- I_solid_rgb  in  24  {R,G,B} for the solid pattern; sampled at frame start only
- O_vs  out  1  vsync, active-high
- O_hs  out  1  hsync, active-high
- O_de  out  1  data enable
- O_data_r  out  8  red
- O_data_g  out  8  green
- O_data_b  out  8  blue
- O_frame_cnt  out  16  completed-frame counter, wraps at 65535

Behaviour:
- All counters are 11-bit; never 10-bit (1280 and 1520 exceed 10 bits).
- hcnt runs 0..H_TOTAL-1. vcnt increments when hcnt = H_TOTAL-1 and wraps to 0 after V_TOTAL-1.
- Frame start is hcnt = 0 and vcnt = 0. At frame start, latch I_pat_sel and I_solid_rgb. Changes mid-frame take effect on the next frame only.
- Timing outputs, computed from the counters:
  - hs = (hcnt < H_SYNC).
  - vs = (vcnt < V_SYNC).
  - de = hcnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID-1] (180..1459) and vcnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID-1] (118..917).
- Pixel coordinates: x = hcnt-180 and y = vcnt-118, valid only while de is high.
- Zone position uses running sub-counters, no dividers:
  - zx counts 0..ZONE-1, clears at the start of each active line; zcol increments when zx wraps.
  - zy and zrow behave the same per active line, clearing at the first active line.
- Pattern colour, per latched select:
  - 0 solid: latched RGB.
  - 1 bars: 8 bars of 160 px. Bar index x[10:7]... use x/160 via a bar counter. Colours in order: white, yellow, cyan, green, magenta, red, blue, black (each channel 255 or 0).
  - 2 ramp: gray g = (x*51)>>8 on all channels; x = 0 gives 0, x = 1279 gives 254.
  - 3 checker: 255 on all channels if (zcol+zrow) is odd, else 0. The partial last column/row (x ≥ 1272, y ≥ 795) follows the same rule.
  - 4 box: black background with a white BOX×BOX square at (bx,by).
    - bx steps +4/-4 and by steps +2/-2 at each frame start.
    - Each axis reverses direction when the next step would exceed the active area; the box never leaves it.
  - 5–7: same as 0.
- Latency: all outputs registered, exactly 1 clock after the counter state they represent. vs, hs, de and data stay mutually aligned.
- RGB is 0 whenever de is low.
- O_frame_cnt increments on the clock where vcnt wraps V_TOTAL-1 → 0 (with hcnt = H_TOTAL-1).
- Reset (synchronous, any time, including mid-line):
  - hcnt, vcnt, sub-counters and O_frame_cnt go to 0.
  - Box returns to (0,0) moving +x,+y.
  - Latched select becomes 0 and latched RGB becomes 0.
  - All outputs are 0 on the clock after I_rst_n is sampled low.
  - The first frame starts on the first clock with I_rst_n high; I_pat_sel is sampled on that clock.

Test Plan:
- Reset, then run 2 frames → hs high 100 clk per 1520-clk line; de high 1280 clk per line on 800 lines; vs high 99 lines of 938; O_frame_cnt = 2.
- pat_sel = 1 → pixel x = 0 is FF/FF/FF; x = 159 is FF/FF/FF; x = 160 is FF/FF/00; x = 1279 is 00/00/00; RGB = 0 in blanking.
- pat_sel = 2 → x = 0 gives 0; x = 640 gives 0x7F; x = 1279 gives 0xFE (all channels).
- pat_sel = 3 → (x=52,y=0) is 0; (x=53,y=0) is 255; (x=53,y=53) is 0; (x=1279,y=799), zone (24,15), is 255.
- Switch pat_sel 0 → 1 at line 400 with I_solid_rgb = 12_34_56 → rest of frame stays 12/34/56; next frame shows bars.
- Assert I_rst_n low for 3 clk at hcnt = 700, vcnt = 300 → outputs 0 after 1 clk; O_frame_cnt = 0; first hs rises on the clock after release; frame timing restarts from 0.

Source files
------------

// File: rtl/vid_pattern_src.sv
// rtl/vid_pattern_src.sv - 1280x800 test-pattern video source (vs/hs/de + 8-bit RGB)
//
// Generates raster timing from two 11-bit counters (hcnt, vcnt) and a pixel
// colour from the pattern selected at each frame start. Every output is
// registered one clock after the counter state it represents.
//
// Ports:
//   I_pix_clk    pixel clock
//   I_rst_n      synchronous active-low reset
//   I_pat_sel    pattern select (0 solid, 1 bars, 2 ramp, 3 checker, 4 box,
//                5-7 solid); latched at frame start
//   I_solid_rgb  {R,G,B} used by the solid pattern; latched at frame start
//   O_vs/O_hs    active-high sync
//   O_de         data enable
//   O_data_r/g/b pixel colour, zero outside de
//   O_frame_cnt  completed-frame counter
module vid_pattern_src #(
    parameter int H_SYNC  = 100,
    parameter int H_BACK  = 80,
    parameter int H_VALID = 1280,
    parameter int H_TOTAL = 1520,
    parameter int V_SYNC  = 99,
    parameter int V_BACK  = 19,
    parameter int V_VALID = 800,
    parameter int V_TOTAL = 938,
    parameter int ZONE    = 53,
    parameter int BOX     = 64,
    parameter int BAR     = 160
) (
    input  logic        I_pix_clk,
    input  logic        I_rst_n,
    input  logic [2:0]  I_pat_sel,
    input  logic [23:0] I_solid_rgb,
    output logic        O_vs,
    output logic        O_hs,
    output logic        O_de,
    output logic [7:0]  O_data_r,
    output logic [7:0]  O_data_g,
    output logic [7:0]  O_data_b,
    output logic [15:0] O_frame_cnt
);

    localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
    localparam logic [10:0] H_START_C = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END_C   = 11'(H_SYNC + H_BACK + H_VALID - 1);
    localparam logic [10:0] H_LAST_C  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VALID_C = 11'(H_VALID);
    localparam logic [10:0] V_SYNC_C  = 11'(V_SYNC);
    localparam logic [10:0] V_START_C = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_END_C   = 11'(V_SYNC + V_BACK + V_VALID - 1);
    localparam logic [10:0] V_LAST_C  = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_VALID_C = 11'(V_VALID);
    localparam logic [10:0] ZONE_C    = 11'(ZONE);
    localparam logic [10:0] BOX_C     = 11'(BOX);
    localparam logic [10:0] BAR_C     = 11'(BAR);
    localparam logic [10:0] BX_STEP   = 11'd4;
    localparam logic [10:0] BY_STEP   = 11'd2;

    logic [10:0] hcnt;
    logic [10:0] vcnt;

    // Running position inside the current zone / bar, advanced per active pixel
    logic [10:0] zx;
    logic [10:0] zcol;
    logic [10:0] zy;
    logic [10:0] zrow;
    logic [10:0] bar_px;
    logic [2:0]  bar_idx;

    logic [2:0]  pat_l;
    logic [23:0] rgb_l;

    logic [10:0] bx;
    logic [10:0] by;
    logic        bx_pos;
    logic        by_pos;

    logic        h_act;
    logic        v_act;
    logic        de_c;
    logic        h_last;
    logic        v_last;
    logic        frame_start;
    logic [10:0] x;
    logic [10:0] y;
    logic [7:0]  gray;
    logic        in_box;
    logic [23:0] bar_rgb;
    logic [23:0] pix;

    always_comb begin
        h_act       = (hcnt >= H_START_C) && (hcnt <= H_END_C);
        v_act       = (vcnt >= V_START_C) && (vcnt <= V_END_C);
        de_c        = h_act && v_act;
        h_last      = (hcnt == H_LAST_C);
        v_last      = (vcnt == V_LAST_C);
        frame_start = (hcnt == 11'd0) && (vcnt == 11'd0);
        x           = hcnt - H_START_C;
        y           = vcnt - V_START_C;
        // x*51/256 approximates x/5 so the ramp spans 0..254 over 1280 pixels
        gray        = 8'((17'(x) * 17'd51) >> 8);
        in_box      = (x >= bx) && (x < bx + BOX_C) && (y >= by) && (y < by + BOX_C);
    end

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx)
            3'd0: bar_rgb = 24'hFFFFFF;
            3'd1: bar_rgb = 24'hFFFF00;
            3'd2: bar_rgb = 24'h00FFFF;
            3'd3: bar_rgb = 24'h00FF00;
            3'd4: bar_rgb = 24'hFF00FF;
            3'd5: bar_rgb = 24'hFF0000;
            3'd6: bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        pix = rgb_l;
        case (pat_l)
            3'd1: pix = bar_rgb;
            3'd2: pix = {gray, gray, gray};
            3'd3: pix = (zcol[0] ^ zrow[0]) ? 24'hFFFFFF : 24'h000000;
            3'd4: pix = in_box ? 24'hFFFFFF : 24'h000000;
            default: pix = rgb_l;
        endcase
    end

    // Raster counters
    always_ff @(posedge I_pix_clk) begin
        if (!I_rst_n) begin
            hcnt <= 11'd0;
            vcnt <= 11'd0;
        end else begin
            hcnt <= h_last ? 11'd0 : hcnt + 11'd1;
            if (h_last) begin
                vcnt <= v_last ? 11'd0 : vcnt + 11'd1;
            end
        end
    end

    // Horizontal sub-counters are cleared one clock before the first active
    // pixel so they already describe x = 0 when that pixel is coloured.
    always_ff @(posedge I_pix_clk) begin
        if (!I_rst_n) begin
            zx      <= 11'd0;
            zcol    <= 11'd0;
            bar_px  <= 11'd0;
            bar_idx <= 3'd0;
        end else if (hcnt == H_START_C - 11'd1) begin
            zx      <= 11'd0;
            zcol    <= 11'd0;
            bar_px  <= 11'd0;
            bar_idx <= 3'd0;
        end else if (h_act) begin
            if (zx == ZONE_C - 11'd1) begin
                zx   <= 11'd0;
                zcol <= zcol + 11'd1;
            end else begin
                zx <= zx + 11'd1;
            end
            if (bar_px == BAR_C - 11'd1) begin
                bar_px <= 11'd0;
                if (bar_idx != 3'd7) begin
                    bar_idx <= bar_idx + 3'd1;
                end
            end else begin
                bar_px <= bar_px + 11'd1;
            end
        end
    end

    // Vertical sub-counters advance at the end of each line
    always_ff @(posedge I_pix_clk) begin
        if (!I_rst_n) begin
            zy   <= 11'd0;
            zrow <= 11'd0;
        end else if (h_last) begin
            if (vcnt == V_START_C - 11'd1) begin
                zy   <= 11'd0;
                zrow <= 11'd0;
            end else if (v_act) begin
                if (zy == ZONE_C - 11'd1) begin
                    zy   <= 11'd0;
                    zrow <= zrow + 11'd1;
                end else begin
                    zy <= zy + 11'd1;
                end
            end
        end
    end

    // Per-frame latches and box motion; a step that would push the box past
    // the active edge is replaced by a step in the opposite direction.
    always_ff @(posedge I_pix_clk) begin
        if (!I_rst_n) begin
            pat_l  <= 3'd0;
            rgb_l  <= 24'd0;
            bx     <= 11'd0;
            by     <= 11'd0;
            bx_pos <= 1'b1;
            by_pos <= 1'b1;
        end else if (frame_start) begin
            pat_l <= I_pat_sel;
            rgb_l <= I_solid_rgb;
            if (bx_pos) begin
                if (bx + BX_STEP + BOX_C <= H_VALID_C) begin
                    bx <= bx + BX_STEP;
                end else begin
                    bx_pos <= 1'b0;
                    bx     <= bx - BX_STEP;
                end
            end else begin
                if (bx >= BX_STEP) begin
                    bx <= bx - BX_STEP;
                end else begin
                    bx_pos <= 1'b1;
                    bx     <= bx + BX_STEP;
                end
            end
            if (by_pos) begin
                if (by + BY_STEP + BOX_C <= V_VALID_C) begin
                    by <= by + BY_STEP;
                end else begin
                    by_pos <= 1'b0;
                    by     <= by - BY_STEP;
                end
            end else begin
                if (by >= BY_STEP) begin
                    by <= by - BY_STEP;
                end else begin
                    by_pos <= 1'b1;
                    by     <= by + BY_STEP;
                end
            end
        end
    end

    // Output registers
    always_ff @(posedge I_pix_clk) begin
        if (!I_rst_n) begin
            O_vs        <= 1'b0;
            O_hs        <= 1'b0;
            O_de        <= 1'b0;
            O_data_r    <= 8'd0;
            O_data_g    <= 8'd0;
            O_data_b    <= 8'd0;
            O_frame_cnt <= 16'd0;
        end else begin
            O_vs <= (vcnt < V_SYNC_C);
            O_hs <= (hcnt < H_SYNC_C);
            O_de <= de_c;
            if (de_c) begin
                O_data_r <= pix[23:16];
                O_data_g <= pix[15:8];
                O_data_b <= pix[7:0];
            end else begin
                O_data_r <= 8'd0;
                O_data_g <= 8'd0;
                O_data_b <= 8'd0;
            end
            if (h_last && v_last) begin
                O_frame_cnt <= O_frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vid_pattern_src.sv
// tb/tb_vid_pattern_src.sv - self-checking bench for vid_pattern_src on a reduced raster
module tb_vid_pattern_src;

    localparam int HS = 4;
    localparam int HB = 3;
    localparam int HV = 40;
    localparam int HT = 50;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int VV = 20;
    localparam int VT = 26;
    localparam int ZN = 7;
    localparam int BXS = 6;
    localparam int BW = 5;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  pat_sel = 3'd0;
    logic [23:0] solid = 24'd0;
    logic        vs, hs, de;
    logic [7:0]  dr, dg, db;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    vid_pattern_src #(
        .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_TOTAL(VT),
        .ZONE(ZN), .BOX(BXS), .BAR(BW)
    ) dut (
        .I_pix_clk(clk),
        .I_rst_n(rst_n),
        .I_pat_sel(pat_sel),
        .I_solid_rgb(solid),
        .O_vs(vs),
        .O_hs(hs),
        .O_de(de),
        .O_data_r(dr),
        .O_data_g(dg),
        .O_data_b(db),
        .O_frame_cnt(frame_cnt)
    );

    // Reference model state: the raster position the DUT is about to output
    int          m_h, m_v, m_frames;
    logic [2:0]  m_pat;
    logic [23:0] m_rgb;
    int          m_bx, m_by;
    bit          m_dx, m_dy;

    int n_chk = 0;
    int n_pass = 0;
    int cnt_hs, cnt_vs, cnt_de;

    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic logic [23:0] ref_pix(int x, int y);
        int b;
        int g;
        case (m_pat)
            3'd1: begin
                b = x / BW;
                if (b > 7) b = 7;
                return bar_tab[b];
            end
            3'd2: begin
                g = (x * 51) >> 8;
                return {8'(g), 8'(g), 8'(g)};
            end
            3'd3: return (((x / ZN) + (y / ZN)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            3'd4: return (x >= m_bx && x < m_bx + BXS && y >= m_by && y < m_by + BXS)
                         ? 24'hFFFFFF : 24'h000000;
            default: return m_rgb;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h (h=%0d v=%0d t=%0t)", tag, obs, exp, m_h, m_v, $time);
    endtask

    task automatic move_box();
        if (m_dx) begin
            if (m_bx + 4 + BXS <= HV) m_bx += 4;
            else begin m_dx = 1'b0; m_bx -= 4; end
        end else begin
            if (m_bx >= 4) m_bx -= 4;
            else begin m_dx = 1'b1; m_bx += 4; end
        end
        if (m_dy) begin
            if (m_by + 2 + BXS <= VV) m_by += 2;
            else begin m_dy = 1'b0; m_by -= 2; end
        end else begin
            if (m_by >= 2) m_by -= 2;
            else begin m_dy = 1'b1; m_by += 2; end
        end
    endtask

    task automatic step();
        logic        ehs, evs, ede;
        logic [23:0] ed;
        @(posedge clk);
        if (!rst_n) begin
            {evs, ehs, ede, ed} = '0;
            m_h = 0; m_v = 0; m_frames = 0;
            m_pat = 3'd0; m_rgb = 24'd0;
            m_bx = 0; m_by = 0; m_dx = 1'b1; m_dy = 1'b1;
        end else begin
            if (m_h == 0 && m_v == 0) begin
                m_pat = pat_sel;
                m_rgb = solid;
                move_box();
            end
            ehs = (m_h < HS);
            evs = (m_v < VS);
            ede = (m_h >= HS + HB) && (m_h < HS + HB + HV) && (m_v >= VS + VB) && (m_v < VS + VB + VV);
            ed  = ede ? ref_pix(m_h - HS - HB, m_v - VS - VB) : 24'd0;
            if (m_h == HT - 1 && m_v == VT - 1) m_frames = (m_frames + 1) % 65536;
            m_h++;
            if (m_h == HT) begin
                m_h = 0;
                m_v++;
                if (m_v == VT) m_v = 0;
            end
        end
        #1;
        chk("pixel", {37'd0, vs, hs, de, dr, dg, db}, {37'd0, evs, ehs, ede, ed});
        chk("frame_cnt", {48'd0, frame_cnt}, 64'(m_frames));
        cnt_hs += int'(hs);
        cnt_vs += int'(vs);
        cnt_de += int'(de);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        solid = 24'($urandom);
        run(3);

        // Two frames of solid colour; count sync/enable duty
        rst_n = 1'b1;
        pat_sel = 3'd0;
        cnt_hs = 0; cnt_vs = 0; cnt_de = 0;
        run(2 * FRAME);
        chk("hs_count", 64'(cnt_hs), 64'(2 * HS * VT));
        chk("vs_count", 64'(cnt_vs), 64'(2 * VS * HT));
        chk("de_count", 64'(cnt_de), 64'(2 * HV * VV));
        chk("frames_2", {48'd0, frame_cnt}, 64'd2);

        // Solid 12/34/56, switch to bars mid-frame: takes effect next frame
        pat_sel = 3'd0;
        solid = 24'h123456;
        run(FRAME / 2);
        pat_sel = 3'd1;
        run(FRAME - FRAME / 2);
        run(FRAME);

        // Each pattern, with a random select change in the middle of the frame
        for (int p = 1; p <= 4; p++) begin
            pat_sel = 3'(p);
            solid = 24'($urandom);
            run(FRAME / 2);
            pat_sel = 3'($urandom_range(0, 7));
            solid = 24'($urandom);
            run(FRAME - FRAME / 2);
        end

        // Moving box long enough to bounce on both axes
        pat_sel = 3'd4;
        run(12 * FRAME);

        // Random selects including the 5-7 aliases
        for (int f = 0; f < 4; f++) begin
            pat_sel = 3'($urandom_range(0, 7));
            solid = 24'($urandom);
            run($urandom_range(1, FRAME - 1));
            pat_sel = 3'($urandom_range(0, 7));
            solid = 24'($urandom);
            while (!(m_h == 0 && m_v == 0)) step();
        end

        // Mid-frame reset
        pat_sel = 3'd2;
        for (int i = 0; i < FRAME && !(m_h == 30 && m_v == 10); i++) step();
        rst_n = 1'b0;
        run(3);
        chk("frames_after_rst", {48'd0, frame_cnt}, 64'd0);
        rst_n = 1'b1;
        pat_sel = 3'd3;
        step();
        chk("hs_after_release", {63'd0, hs}, 64'd1);
        cnt_de = 0;
        run(FRAME - 1);
        chk("de_count_after_rst", 64'(cnt_de), 64'(HV * VV));
        pat_sel = 3'd4;
        run(FRAME);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
